mem_access_unit: RTL and testbench

Load/store initiator for the MEM stage. Accepts one byte-addressed load or store at a time from the pipeline and drives the word-indexed data memory's read/write ports (read address, write address, read, write, write data, read data). It performs alignment checks, sub-word extraction with sign or zero extension, and read-modify-write for byte and halfword stores. It returns a single-cycle response and holds `stall` while busy.

---
 rtl/mau_pkg.sv | 19 +
 rtl/mau_lane_align.sv | 62 ++++++
 rtl/mem_access_unit.sv | 192 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mau_pkg.sv
// mau_pkg: shared size codes, FSM states and defaults
// for the mem_access_unit load/store initiator.
package mau_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam int MAU_DEPTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CAP,
    ST_WR,
    ST_RESP
  } mau_state_t;

endpackage

// File: rtl/mau_lane_align.sv
// mau_lane_align: sub-word extract/extend for loads and
// byte/half merge for stores (built with MAU_SUBWORD_EN).
`ifdef MAU_SUBWORD_EN
module mau_lane_align
  import mau_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merge
);

  logic [7:0]  w_b;
  logic [15:0] w_h;

  always_comb begin
    w_b = i_word[7:0];
    unique case (i_lane)
      2'd0: w_b = i_word[7:0];
      2'd1: w_b = i_word[15:8];
      2'd2: w_b = i_word[23:16];
      2'd3: w_b = i_word[31:24];
      default: w_b = i_word[7:0];
    endcase
    w_h = i_lane[1] ? i_word[31:16] : i_word[15:0];
  end

  always_comb begin
    o_load = i_word;
    unique case (i_size)
      SZ_B: o_load = {{24{i_signed & w_b[7]}}, w_b};
      SZ_H: o_load = {{16{i_signed & w_h[15]}}, w_h};
      default: o_load = i_word;
    endcase
  end

  // Only the addressed lane changes; the rest comes from the read word.
  always_comb begin
    o_merge = i_word;
    unique case (i_size)
      SZ_B: begin
        unique case (i_lane)
          2'd0: o_merge[7:0]   = i_wdata[7:0];
          2'd1: o_merge[15:8]  = i_wdata[7:0];
          2'd2: o_merge[23:16] = i_wdata[7:0];
          2'd3: o_merge[31:24] = i_wdata[7:0];
          default: o_merge = i_word;
        endcase
      end
      SZ_H: begin
        if (i_lane[1]) o_merge[31:16] = i_wdata[15:0];
        else           o_merge[15:0]  = i_wdata[15:0];
      end
      default: o_merge = i_wdata;
    endcase
  end

endmodule
`endif

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store initiator for a word-indexed
// data memory. Define MAU_SUBWORD_EN for byte/half accesses.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int DEPTH = MAU_DEPTH,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  output logic [31:0]   resp_rdata,
  output logic          resp_err,
  output logic          stall,
  output logic [31:0]   mem_raddr,
  output logic [31:0]   mem_waddr,
  output logic          mem_read,
  output logic          mem_write,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam int IW = AW - 2;
`ifdef MAU_SUBWORD_EN
  localparam bit SUBWORD = 1'b1;
`else
  localparam bit SUBWORD = 1'b0;
`endif

  mau_state_t  r_state;
  logic        r_err;
  logic [31:0] r_data;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic [31:0] r_resp_rdata;
  logic        r_mem_read;
  logic        r_mem_write;
  logic [31:0] r_mem_raddr;
  logic [31:0] r_mem_waddr;
  logic [31:0] r_mem_wdata;

  logic          w_accept;
  logic          w_err;
  logic          w_range;
  logic [IW-1:0] w_idx;
  logic [31:0]   w_idx32;
  logic [31:0]   w_ld;

  assign w_accept = req_valid && req_ready;
  assign w_idx    = req_addr[AW-1:2];
  assign w_idx32  = 32'(w_idx);
  assign w_range  = {{(64-IW){1'b0}}, w_idx} >= 64'(DEPTH);

  always_comb begin
    w_err = 1'b1;
    unique case (req_size)
      SZ_B:    w_err = !SUBWORD;
      SZ_H:    w_err = !SUBWORD || req_addr[0];
      SZ_W:    w_err = |req_addr[1:0];
      default: w_err = 1'b1;
    endcase
    if (w_range) w_err = 1'b1;
  end

`ifdef MAU_SUBWORD_EN
  logic        r_write;
  logic        r_signed;
  logic [1:0]  r_size;
  logic [1:0]  r_lane;
  logic [31:0] r_idx;
  logic [31:0] r_wdata;
  logic [31:0] w_merge;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_write  <= 1'b0;
      r_signed <= 1'b0;
      r_size   <= SZ_W;
      r_lane   <= 2'd0;
      r_idx    <= '0;
      r_wdata  <= '0;
    end else if (w_accept) begin
      r_write  <= req_write;
      r_signed <= req_signed;
      r_size   <= req_size;
      r_lane   <= req_addr[1:0];
      r_idx    <= w_idx32;
      r_wdata  <= req_wdata;
    end
  end

  mau_lane_align u_align (
    .i_word  (mem_rdata),
    .i_lane  (r_lane),
    .i_size  (r_size),
    .i_signed(r_signed),
    .i_wdata (r_wdata),
    .o_load  (w_ld),
    .o_merge (w_merge)
  );
`else
  assign w_ld = mem_rdata;
`endif

  // Memory strobes and response are registered one state ahead.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_err        <= 1'b0;
      r_data       <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_raddr  <= '0;
      r_mem_waddr  <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_err  <= w_err;
            r_data <= '0;
            if (w_err) begin
              r_state <= ST_RESP;
            end else if (req_write &&
                         req_size == SZ_W) begin
              r_state     <= ST_WR;
              r_mem_write <= 1'b1;
              r_mem_waddr <= w_idx32;
              r_mem_wdata <= req_wdata;
            end else begin
              r_state     <= ST_RD;
              r_mem_read  <= 1'b1;
              r_mem_raddr <= w_idx32;
            end
          end
        end
        ST_RD: r_state <= ST_CAP;
        ST_CAP: begin
`ifdef MAU_SUBWORD_EN
          if (r_write) begin
            r_state     <= ST_WR;
            r_mem_write <= 1'b1;
            r_mem_waddr <= r_idx;
            r_mem_wdata <= w_merge;
          end else begin
            r_data  <= w_ld;
            r_state <= ST_RESP;
          end
`else
          r_data  <= w_ld;
          r_state <= ST_RESP;
`endif
        end
        ST_WR: r_state <= ST_RESP;
        ST_RESP: begin
          r_resp_valid <= 1'b1;
          r_resp_err   <= r_err;
          r_resp_rdata <= r_data;
          r_state      <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign stall      = (r_state != ST_IDLE) || r_resp_valid;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;
  assign mem_read   = r_mem_read;
  assign mem_write  = r_mem_write;
  assign mem_raddr  = r_mem_raddr;
  assign mem_waddr  = r_mem_waddr;
  assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: random and directed load/store traffic
// against a byte-level reference model of memory.
module tb_mem_access_unit;

  localparam int DEPTH = 32;
`ifdef MAU_SUBWORD_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b10;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        stall;
  logic [31:0] mem_raddr;
  logic [31:0] mem_waddr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  mem_access_unit #(.DEPTH(DEPTH), .AW(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .stall(stall),
    .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [31:0] mem [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  bit          pend = 1'b0;
  int          exp_cyc = 0;
  int          exp_nrd = 0;
  int          exp_nwr = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  bit          exp_err = 1'b0;
  logic [31:0] exp_rd = '0;
  logic [31:0] exp_idx = '0;
  logic [31:0] exp_new = '0;
  logic [31:0] last_rd = '0;
  bit          last_err = 1'b0;
  int          last_acc = -1;
  int          last_lat = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Word-indexed memory with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_read && mem_raddr < DEPTH)
      mem_rdata <= mem[mem_raddr[4:0]];
    if (mem_write && mem_waddr < DEPTH)
      mem[mem_waddr[4:0]] <= mem_wdata;
  end

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  function automatic void fail(string nm);
    total++;
    bad++;
    $display("FAIL %s", nm);
  endfunction

  function automatic void model(
    input  bit          wr,
    input  logic [1:0]  sz,
    input  bit          sg,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output bit          err,
    output logic [31:0] rd,
    output int          lat,
    output int          nr,
    output int          nw,
    output logic [31:0] nword
  );
    int nb;
    int off;
    logic [63:0] mask;
    logic [31:0] w;
    logic [31:0] v;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 :
         (sz == 2'd2) ? 4 : 0;
    err = (nb == 0);
    if (!err) err = (addr % nb) != 0;
    err = err || (addr / 4 >= DEPTH) || (!SUB && nb != 4);
    rd = '0;
    nword = '0;
    lat = 1;
    nr = 0;
    nw = 0;
    if (err) return;
    off = int'(addr % 4);
    w = ref_mem[addr / 4];
    mask = (64'd1 << (8 * nb)) - 64'd1;
    if (!wr) begin
      v = 32'((64'(w) >> (8 * off)) & mask);
      if (sg && nb < 4 && v[8 * nb - 1]) v = v | ~32'(mask);
      rd = v;
      lat = 3;
      nr = 1;
    end else begin
      nword = 32'((64'(w) & ~(mask << (8 * off))) |
                  ((64'(wd) & mask) << (8 * off)));
      lat = (nb == 4) ? 2 : 4;
      nr = (nb == 4) ? 0 : 1;
      nw = 1;
    end
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_read && mem_write) fail("rd_wr_overlap");
      chk("req_ready", 32'(req_ready),
          32'(!pend || cyc == exp_cyc));
      chk("stall", 32'(stall), 32'(pend));
      if (mem_read) begin
        if (!pend) fail("read_when_idle");
        else begin
          rd_cnt++;
          chk("raddr", mem_raddr, exp_idx);
        end
      end
      if (mem_write) begin
        if (!pend) fail("write_when_idle");
        else begin
          wr_cnt++;
          chk("waddr", mem_waddr, exp_idx);
          chk("wdata", mem_wdata, exp_new);
        end
      end
      if (resp_valid) begin
        if (!pend) fail("spurious_resp");
        else begin
          chk("latency", 32'(cyc), 32'(exp_cyc));
          chk("resp_err", 32'(resp_err), 32'(exp_err));
          chk("resp_rdata", resp_rdata, exp_rd);
          chk("n_reads", 32'(rd_cnt), 32'(exp_nrd));
          chk("n_writes", 32'(wr_cnt), 32'(exp_nwr));
          last_rd = resp_rdata;
          last_err = resp_err;
          pend = 1'b0;
        end
      end else if (pend && cyc >= exp_cyc) begin
        fail("missing_resp");
        pend = 1'b0;
      end
    end
  end

  task automatic issue(input bit wr, input logic [1:0] sz,
                       input bit sg, input logic [31:0] addr,
                       input logic [31:0] wd, input bit chain,
                       input bit drop);
    int n;
    bit e;
    logic [31:0] rd;
    logic [31:0] nword;
    int lat;
    int nr;
    int nw;
    n = 0;
    @(negedge clk);
    #1;
    while (!req_ready && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!req_ready) begin
      fail("ready_timeout");
      return;
    end
    req_valid = 1'b1;
    req_write = wr;
    req_size = sz;
    req_signed = sg;
    req_addr = addr;
    req_wdata = wd;
    model(wr, sz, sg, addr, wd, e, rd, lat, nr, nw, nword);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr = $urandom;
    req_wdata = $urandom;
    if (chain && last_acc >= 0)
      chk("throughput", 32'(cyc), 32'(last_acc + last_lat + 1));
    last_acc = cyc;
    last_lat = lat;
    exp_cyc = cyc + lat;
    exp_err = e;
    exp_rd = rd;
    exp_nrd = nr;
    exp_nwr = nw;
    exp_idx = addr / 4;
    exp_new = nword;
    rd_cnt = 0;
    wr_cnt = 0;
    if (!drop) begin
      pend = 1'b1;
      if (wr && !e) ref_mem[addr / 4] = nword;
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (pend && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (pend) begin
      fail("resp_timeout");
      pend = 1'b0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    bit          wr;
    bit          sg;
    bit          ch;
    logic [1:0]  sz;
    logic [31:0] a;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[3] = 32'h8899AABB;
    ref_mem[3] = 32'h8899AABB;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_raddr", mem_raddr, 32'd0);
    chk("rst_waddr", mem_waddr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    issue(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 1'b0, 1'b0);
    wait_done();
    chk("lit_lw", last_rd, 32'h8899AABB);
    chk("lit_lw_err", 32'(last_err), 32'd0);

    issue(1'b0, 2'b00, 1'b1, 32'h0D, 32'h0, 1'b0, 1'b0);
    wait_done();
`ifdef MAU_SUBWORD_EN
    chk("lit_lb_s", last_rd, 32'hFFFFFFAA);
`else
    chk("lit_lb_s_err", 32'(last_err), 32'd1);
`endif
    issue(1'b0, 2'b00, 1'b0, 32'h0D, 32'h0, 1'b0, 1'b0);
    wait_done();
`ifdef MAU_SUBWORD_EN
    chk("lit_lb_u", last_rd, 32'h000000AA);
`else
    chk("lit_lb_u_err", 32'(last_err), 32'd1);
`endif
    issue(1'b0, 2'b01, 1'b1, 32'h0E, 32'h0, 1'b0, 1'b0);
    wait_done();
`ifdef MAU_SUBWORD_EN
    chk("lit_lh_s", last_rd, 32'hFFFF8899);
`else
    chk("lit_lh_s_err", 32'(last_err), 32'd1);
`endif
    issue(1'b1, 2'b00, 1'b0, 32'h0E, 32'h55, 1'b0, 1'b0);
    wait_done();
`ifdef MAU_SUBWORD_EN
    chk("lit_sb_mem", mem[3], 32'h8855AABB);
`else
    chk("lit_sb_mem", mem[3], 32'h8899AABB);
`endif

    issue(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 1'b0, 1'b0);
    wait_done();
    chk("lit_misalign_w", 32'(last_err), 32'd1);
    issue(1'b0, 2'b01, 1'b0, 32'h01, 32'h0, 1'b0, 1'b0);
    wait_done();
    chk("lit_misalign_h", 32'(last_err), 32'd1);
    issue(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 1'b0, 1'b0);
    wait_done();
    chk("lit_range", 32'(last_err), 32'd1);

`ifdef MAU_SUBWORD_EN
    issue(1'b1, 2'b00, 1'b0, 32'h0C, 32'hA5, 1'b0, 1'b1);
`else
    issue(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 1'b0, 1'b1);
`endif
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("drop_ready", 32'(req_ready), 32'd1);
    repeat (6) @(negedge clk);
`ifdef MAU_SUBWORD_EN
    chk("drop_mem", mem[3], 32'h8855AABB);
`else
    chk("drop_mem", mem[3], 32'h8899AABB);
`endif
    issue(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 1'b0, 1'b0);
    wait_done();
`ifdef MAU_SUBWORD_EN
    chk("post_drop_lw", last_rd, 32'h8855AABB);
`else
    chk("post_drop_lw", last_rd, 32'h8899AABB);
`endif

    for (int i = 0; i < 300; i++) begin
      wr = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 :
           2'($urandom_range(0, 2));
      a = ($urandom_range(0, 9) == 0) ?
          32'($urandom_range(DEPTH * 4, DEPTH * 4 + 64)) :
          32'($urandom_range(0, DEPTH * 4 - 1));
      ch = (i > 0) && ($urandom_range(0, 3) != 0);
      if (!ch) begin
        wait_done();
        repeat ($urandom_range(0, 2)) @(posedge clk);
      end
      issue(wr, sz, sg, a, $urandom, ch, 1'b0);
    end
    wait_done();
    repeat (3) @(negedge clk);

    for (int i = 0; i < DEPTH; i++)
      chk("final_mem", mem[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
